// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle SLL/SRL/SRA/ROR of a W-bit operand.
// Each cycle it applies a STEP-bit stage while at least STEP bits remain, otherwise a 1-bit stage.
module iter_shifter #(
    parameter int W       = 32,
    parameter int STEP    = 4,
    parameter int SHAMT_W = $clog2(W)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         ctrl_shiftop,
    input  logic [SHAMT_W-1:0] ctrl_shiftamt,
    input  logic [W-1:0]       data_operandA,
    output logic               ready,
    output logic               data_resultRDY,
    output logic [W-1:0]       data_result
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t             state;
    logic [W-1:0]       sr, coarse, fine, nxt;
    logic [SHAMT_W-1:0] rem, rem_nxt;
    logic [1:0]         op;
    logic               sgn, big;

    // op[1] selects sign fill for the right shifts: SRL=01 fills 0, SRA=10 fills the latched sign
    always_comb begin
        big     = rem >= SHAMT_W'(STEP);
        coarse  = op == 2'b00 ? {sr[W-STEP-1:0], {STEP{1'b0}}} :
                  op == 2'b11 ? {sr[STEP-1:0], sr[W-1:STEP]} :
                                {{STEP{op[1] & sgn}}, sr[W-1:STEP]};
        fine    = op == 2'b00 ? {sr[W-2:0], 1'b0} :
                  op == 2'b11 ? {sr[0], sr[W-1:1]} :
                                {op[1] & sgn, sr[W-1:1]};
        nxt     = big ? coarse : fine;
        rem_nxt = rem - (big ? SHAMT_W'(STEP) : SHAMT_W'(1));
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state          <= IDLE;
            sr             <= '0;
            rem            <= '0;
            op             <= '0;
            sgn            <= 1'b0;
            data_result    <= '0;
            data_resultRDY <= 1'b0;
            ready          <= 1'b1;
        end else if (state == SHIFT) begin
            sr  <= nxt;
            rem <= rem_nxt;
            if (rem_nxt == '0) begin
                state          <= DONE;
                data_result    <= nxt;
                data_resultRDY <= 1'b1;
                ready          <= 1'b1;
            end
        end else if (start) begin
            sr             <= data_operandA;
            rem            <= ctrl_shiftamt;
            op             <= ctrl_shiftop;
            sgn            <= data_operandA[W-1];
            state          <= ctrl_shiftamt == '0 ? DONE : SHIFT;
            data_resultRDY <= ctrl_shiftamt == '0;
            ready          <= ctrl_shiftamt == '0;
            if (ctrl_shiftamt == '0)
                data_result <= data_operandA;
        end else begin
            state          <= IDLE;
            data_resultRDY <= 1'b0;
            ready          <= 1'b1;
        end
    end
endmodule

// File: tb/tb_iter_shifter.sv
// tb_iter_shifter: three iter_shifter instances (STEP 1, 4, 16) fed identical stimulus,
// checked against an arithmetic reference model for result, latency and handshake.
module tb_iter_shifter;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op    = '0;
    logic [4:0]  amt   = '0;
    logic [31:0] opa   = '0;
    logic [2:0]  rd, rdy;
    logic [31:0] res [3];
    int vecs = 0;
    int errs = 0;

    iter_shifter #(.W(32), .STEP(1)) u0 (.clock(clock), .reset(reset), .start(start), .ctrl_shiftop(op),
        .ctrl_shiftamt(amt), .data_operandA(opa), .ready(rd[0]), .data_resultRDY(rdy[0]), .data_result(res[0]));
    iter_shifter #(.W(32), .STEP(4)) u1 (.clock(clock), .reset(reset), .start(start), .ctrl_shiftop(op),
        .ctrl_shiftamt(amt), .data_operandA(opa), .ready(rd[1]), .data_resultRDY(rdy[1]), .data_result(res[1]));
    iter_shifter #(.W(32), .STEP(16)) u2 (.clock(clock), .reset(reset), .start(start), .ctrl_shiftop(op),
        .ctrl_shiftamt(amt), .data_operandA(opa), .ready(rd[2]), .data_resultRDY(rdy[2]), .data_result(res[2]));

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  o;
        logic [4:0]  s;
        logic [31:0] a;
        logic [31:0] e;
        bit          poke;
    } vec_t;

    function automatic int step_of(input int i);
        return i == 0 ? 1 : i == 1 ? 4 : 16;
    endfunction

    function automatic int klat(input int s, input int st);
        return s / st + s % st;
    endfunction

    function automatic logic [31:0] model(input logic [1:0] o, input int s, input logic [31:0] a);
        case (o)
            2'd0:    return a << s;
            2'd1:    return a >> s;
            2'd2:    return 32'($signed(a) >>> s);
            default: return s == 0 ? a : (a >> s) | (a << (32 - s));
        endcase
    endfunction

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", n, got, exp);
        end
    endtask

    // One operation: accept at cycle 0, inputs scrambled afterwards, optional junk start during SHIFT
    task automatic run_op(input logic [1:0] o, input logic [4:0] s, input logic [31:0] a,
                          input logic [31:0] e, input bit poke);
        int first[3], cnt[3], busy[3];
        for (int i = 0; i < 3; i++) begin
            first[i] = 0; cnt[i] = 0; busy[i] = 0;
        end
        @(negedge clock);
        start = 1'b1; op = o; amt = s; opa = a;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            for (int i = 0; i < 3; i++) begin
                if (!rd[i]) busy[i]++;
                if (rdy[i]) begin
                    cnt[i]++;
                    if (first[i] == 0) first[i] = c;
                    chk($sformatf("result_s%0d_op%0d_amt%0d", step_of(i), o, s), res[i], e);
                    chk($sformatf("ready_at_done_s%0d", step_of(i)), 32'(rd[i]), 32'd1);
                end
            end
            if (c == 1) begin
                start = 1'b0; op = ~o; amt = ~s; opa = ~a;
            end
            start = poke && (c == 2 || c == 3);
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("latency_s%0d_amt%0d", step_of(i), s), first[i], klat(s, step_of(i)) + 1);
            chk($sformatf("pulses_s%0d", step_of(i)), cnt[i], 1);
            chk($sformatf("busy_cycles_s%0d_amt%0d", step_of(i), s), busy[i], klat(s, step_of(i)));
            chk($sformatf("held_s%0d", step_of(i)), res[i], e);
        end
    endtask

    initial begin
        vec_t tbl[7];
        int   first[3], cnt;
        tbl[0] = '{2'd2, 5'd4,  32'h8000_0000, 32'hF800_0000, 1'b0};
        tbl[1] = '{2'd1, 5'd31, 32'h8000_0000, 32'h0000_0001, 1'b0};
        tbl[2] = '{2'd2, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0};
        tbl[3] = '{2'd0, 5'd0,  32'h0000_0001, 32'h0000_0001, 1'b0};
        tbl[4] = '{2'd0, 5'd13, 32'h0000_000F, 32'h0001_E000, 1'b1};
        tbl[5] = '{2'd3, 5'd8,  32'h1234_5678, 32'h7812_3456, 1'b0};
        tbl[6] = '{2'd2, 5'd1,  32'h8000_0002, 32'hC000_0001, 1'b0};

        repeat (2) @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_ready_s%0d", step_of(i)), 32'(rd[i]), 32'd1);
            chk($sformatf("reset_rdy_s%0d", step_of(i)), 32'(rdy[i]), 32'd0);
            chk($sformatf("reset_result_s%0d", step_of(i)), res[i], 32'd0);
        end
        reset = 1'b1;

        for (int t = 0; t < 7; t++)
            run_op(tbl[t].o, tbl[t].s, tbl[t].a, tbl[t].e, tbl[t].poke);

        // back-to-back: zero-amount op, then ROR 8 accepted in its DONE cycle
        @(negedge clock);
        start = 1'b1; op = 2'd0; amt = 5'd0; opa = 32'h1;
        @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("b2b_first_rdy_s%0d", step_of(i)), 32'(rdy[i]), 32'd1);
            chk($sformatf("b2b_first_res_s%0d", step_of(i)), res[i], 32'h1);
            first[i] = 0;
        end
        start = 1'b1; op = 2'd3; amt = 5'd8; opa = 32'h1234_5678;
        for (int c = 2; c <= 40; c++) begin
            @(negedge clock);
            start = 1'b0;
            for (int i = 0; i < 3; i++) begin
                if (c == 2) chk($sformatf("b2b_hold_s%0d", step_of(i)), res[i], 32'h1);
                if (rdy[i] && first[i] == 0) begin
                    first[i] = c;
                    chk($sformatf("b2b_res_s%0d", step_of(i)), res[i], 32'h7812_3456);
                end
            end
        end
        for (int i = 0; i < 3; i++)
            chk($sformatf("b2b_latency_s%0d", step_of(i)), first[i], 1 + klat(8, step_of(i)) + 1);

        // reset during SHIFT aborts without a result pulse
        cnt = 0;
        @(negedge clock);
        start = 1'b1; op = 2'd2; amt = 5'd20; opa = 32'hF000_0000;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            start = 1'b0;
            cnt += int'(rdy[0]) + int'(rdy[1]) + int'(rdy[2]);
            if (c == 4)
                for (int i = 0; i < 3; i++) begin
                    chk($sformatf("abort_ready_s%0d", step_of(i)), 32'(rd[i]), 32'd1);
                    chk($sformatf("abort_result_s%0d", step_of(i)), res[i], 32'd0);
                end
            reset = c != 3;
        end
        chk("abort_no_pulse", cnt, 0);
        run_op(2'd1, 5'd5, 32'hA5A5_0000, 32'h052D_2800, 1'b0);

        for (int o = 0; o < 4; o++)
            for (int s = 0; s < 32; s++) begin
                logic [31:0] a;
                a = $urandom;
                run_op(2'(o), 5'(s), a, model(2'(o), s, a), 1'b0);
            end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
